// File: rtl/seven_seg_pkg.sv
// Shared definitions for the Basys-2 seven-segment display path.
// Holds the glyph table (active-low {g,f,e,d,c,b,a}), the blank pattern,
// the digit count, the capture FSM state type and small anode helpers.
// The display driver and the capture block both import this package, so
// they use one glyph table.
package seven_seg_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] GLYPH_0     = 7'h40;
    localparam logic [6:0] GLYPH_1     = 7'h79;
    localparam logic [6:0] GLYPH_2     = 7'h24;
    localparam logic [6:0] GLYPH_3     = 7'h30;
    localparam logic [6:0] GLYPH_4     = 7'h19;
    localparam logic [6:0] GLYPH_5     = 7'h12;
    localparam logic [6:0] GLYPH_6     = 7'h02;
    localparam logic [6:0] GLYPH_7     = 7'h78;
    localparam logic [6:0] GLYPH_8     = 7'h00;
    localparam logic [6:0] GLYPH_9     = 7'h10;
    localparam logic [6:0] GLYPH_A     = 7'h08;
    localparam logic [6:0] GLYPH_B     = 7'h03;
    localparam logic [6:0] GLYPH_C     = 7'h46;
    localparam logic [6:0] GLYPH_D     = 7'h21;
    localparam logic [6:0] GLYPH_E     = 7'h06;
    localparam logic [6:0] GLYPH_F     = 7'h0E;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        LATCHED = 2'd2
    } capture_state_t;

    // Nibble -> cathode pattern, used by the driver side.
    function automatic logic [6:0] glyph_of(input logic [3:0] nibble);
        logic [6:0] g;
        case (nibble)
            4'h0: g = GLYPH_0;
            4'h1: g = GLYPH_1;
            4'h2: g = GLYPH_2;
            4'h3: g = GLYPH_3;
            4'h4: g = GLYPH_4;
            4'h5: g = GLYPH_5;
            4'h6: g = GLYPH_6;
            4'h7: g = GLYPH_7;
            4'h8: g = GLYPH_8;
            4'h9: g = GLYPH_9;
            4'hA: g = GLYPH_A;
            4'hB: g = GLYPH_B;
            4'hC: g = GLYPH_C;
            4'hD: g = GLYPH_D;
            4'hE: g = GLYPH_E;
            default: g = GLYPH_F;
        endcase
        return g;
    endfunction

    // Number of anodes driven low (active-low lines).
    function automatic logic [2:0] low_count(input logic [3:0] an);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            n = n + {2'b00, ~an[i]};
        end
        return n;
    endfunction

    // Index of the low anode; only meaningful when exactly one is low.
    function automatic logic [1:0] low_index(input logic [3:0] an);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seven_seg_capture_if.sv
// Bundle of the snooped display bus and the reconstructed-digit outputs.
//   an[3:0]          active-low anodes, an[0] = rightmost digit
//   seg[6:0]         active-low cathodes {g,f,e,d,c,b,a}
//   dp               active-low decimal-point cathode
//   digits[15:0]     captured nibbles, digit i at [4i+3:4i]
//   dp_out[3:0]      captured decimal points, active-high
//   digit_valid[3:0] digit i's latest capture was a legal hex glyph
//   decode_err[3:0]  digit i's latest capture was neither hex nor blank
//   bus_err          sticky multiple-anode-low flag
//   update           one-cycle capture strobe
//   update_idx[1:0]  digit index of the capture
//   fsm_state        capture FSM state, for observation
// Strobe semantics: there is no back-pressure. update is high for exactly
// one cycle per capture; update_idx and the capture registers already hold
// the new values in that cycle, and the consumer must take them then.
// The master modport drives the display bus; the slave modport is the
// capture block.
interface seven_seg_capture_if;
    import seven_seg_pkg::*;

    logic [3:0]                  an;
    logic [6:0]                  seg;
    logic                        dp;
    logic [4*NUM_DIGITS-1:0]     digits;
    logic [NUM_DIGITS-1:0]       dp_out;
    logic [NUM_DIGITS-1:0]       digit_valid;
    logic [NUM_DIGITS-1:0]       decode_err;
    logic                        bus_err;
    logic                        update;
    logic [1:0]                  update_idx;
    capture_state_t              fsm_state;

    modport master (
        output an, seg, dp,
        input  digits, dp_out, digit_valid, decode_err, bus_err,
               update, update_idx, fsm_state
    );

    modport slave (
        input  an, seg, dp,
        output digits, dp_out, digit_valid, decode_err, bus_err,
               update, update_idx, fsm_state
    );

endinterface

// File: rtl/seven_seg_glyph_decode.sv
// Combinational cathode-pattern classifier.
//   seg[6:0]    active-low cathodes {g,f,e,d,c,b,a}
//   is_hex      pattern is one of the 16 hex glyphs
//   is_blank    pattern is all segments off
//   nibble[3:0] hex value when is_hex, else 0
module seven_seg_glyph_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic       is_hex,
    output logic       is_blank,
    output logic [3:0] nibble
);

    always_comb begin
        is_hex   = 1'b1;
        is_blank = 1'b0;
        nibble   = 4'h0;
        case (seg)
            GLYPH_0: nibble = 4'h0;
            GLYPH_1: nibble = 4'h1;
            GLYPH_2: nibble = 4'h2;
            GLYPH_3: nibble = 4'h3;
            GLYPH_4: nibble = 4'h4;
            GLYPH_5: nibble = 4'h5;
            GLYPH_6: nibble = 4'h6;
            GLYPH_7: nibble = 4'h7;
            GLYPH_8: nibble = 4'h8;
            GLYPH_9: nibble = 4'h9;
            GLYPH_A: nibble = 4'hA;
            GLYPH_B: nibble = 4'hB;
            GLYPH_C: nibble = 4'hC;
            GLYPH_D: nibble = 4'hD;
            GLYPH_E: nibble = 4'hE;
            GLYPH_F: nibble = 4'hF;
            GLYPH_BLANK: begin
                is_hex   = 1'b0;
                is_blank = 1'b1;
            end
            default: is_hex = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Seven-segment bus snooper: reconstructs the four multiplexed digits and
// decimal points from the active-low anode/cathode lines.
//   clock   system clock
//   reset   synchronous active-high reset
//   ss      seven_seg_capture_if.slave (display bus in, captured digits out)
// Parameters:
//   SETTLE_CYCLES  identical samples with one anode low needed per capture
//   CNT_W          stability counter width (holds SETTLE_CYCLES-1)
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    seven_seg_capture_if.slave   ss
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES - 1);
    // Sample value after reset looks like an idle bus (everything off), so
    // any dwell present when reset releases is seen as a fresh change.
    localparam logic [11:0]      S_IDLE  = 12'hFFF;

    logic [11:0]      in_vec;
    logic [11:0]      s_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_changed;
    logic             in_one_hot;
    logic             in_multi_low;

    logic [3:0]       s_an;
    logic [6:0]       s_seg;
    logic             s_dp;

    capture_state_t   state_q, state_d;
    logic             capture;
    logic [1:0]       cap_idx;

    logic             dec_hex;
    logic             dec_blank;
    logic [3:0]       dec_nibble;

    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [NUM_DIGITS-1:0]   dp_q;
    logic [NUM_DIGITS-1:0]   valid_q;
    logic [NUM_DIGITS-1:0]   err_q;
    logic                    bus_err_q;
    logic                    update_q;
    logic [1:0]              update_idx_q;

    assign in_vec       = {ss.an, ss.seg, ss.dp};
    assign in_changed   = (in_vec != s_q);
    assign in_one_hot   = (low_count(ss.an) == 3'd1);
    assign in_multi_low = (low_count(ss.an) >= 3'd2);

    assign s_an  = s_q[11:8];
    assign s_seg = s_q[7:1];
    assign s_dp  = s_q[0];

    // A capture only happens when the input equals s, so s is the dwell.
    assign cap_idx = low_index(s_an);

    seven_seg_glyph_decode u_decode (
        .seg      (s_seg),
        .is_hex   (dec_hex),
        .is_blank (dec_blank),
        .nibble   (dec_nibble)
    );

    // Next-state logic. Any input change restarts qualification from the
    // new value; LATCHED simply waits for that change, so one dwell yields
    // at most one capture.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        if (in_changed) begin
            state_d = in_one_hot ? SETTLE : IDLE;
        end else begin
            case (state_q)
                SETTLE: begin
                    if (cnt_q == CNT_MAX) begin
                        capture = 1'b1;
                        state_d = LATCHED;
                    end
                end
                default: state_d = state_q;
            endcase
        end
        if (in_multi_low) begin
            state_d = IDLE;
            capture = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Input sample and stability counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            s_q   <= S_IDLE;
            cnt_q <= '0;
        end else begin
            s_q <= in_vec;
            if (in_changed) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Capture registers. Only the addressed digit's fields are written.
    always_ff @(posedge clock) begin
        if (reset) begin
            digits_q     <= '0;
            dp_q         <= '0;
            valid_q      <= '0;
            err_q        <= '0;
            bus_err_q    <= 1'b0;
            update_q     <= 1'b0;
            update_idx_q <= 2'd0;
        end else begin
            if (in_multi_low) begin
                bus_err_q <= 1'b1;
            end
            update_q <= capture;
            if (capture) begin
                update_idx_q     <= cap_idx;
                dp_q[cap_idx]    <= ~s_dp;
                valid_q[cap_idx] <= dec_hex;
                err_q[cap_idx]   <= ~dec_hex & ~dec_blank;
                if (dec_hex) begin
                    digits_q[{cap_idx, 2'b00} +: 4] <= dec_nibble;
                end
            end
        end
    end

    assign ss.digits      = digits_q;
    assign ss.dp_out      = dp_q;
    assign ss.digit_valid = valid_q;
    assign ss.decode_err  = err_q;
    assign ss.bus_err     = bus_err_q;
    assign ss.update      = update_q;
    assign ss.update_idx  = update_idx_q;
    assign ss.fsm_state   = state_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
module tb_seven_seg_capture;
    import seven_seg_pkg::*;

    localparam int SETTLE = 4;

    logic       clk;
    logic       rst_drv;
    logic [3:0] an_drv;
    logic [6:0] seg_drv;
    logic       dp_drv;

    int n_total = 0;
    int n_bad   = 0;
    int edge_n  = 0;
    int upd_cnt = 0;

    seven_seg_capture_if ss_if ();

    assign ss_if.an  = an_drv;
    assign ss_if.seg = seg_drv;
    assign ss_if.dp  = dp_drv;

    seven_seg_capture #(
        .SETTLE_CYCLES (SETTLE),
        .CNT_W         (16)
    ) dut (
        .clock (clk),
        .reset (rst_drv),
        .ss    (ss_if)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Expected behaviour from the display rules: a value with exactly one
    // anode low that has been presented on SETTLE+1 consecutive edges is
    // captured on the last of those edges, once per run.
    logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        int          tag;
        logic [30:0] vec;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] nib_m [4];
    logic       val_m [4];
    logic       err_m [4];
    logic       dpo_m [4];
    logic       berr_m;
    int         run_len;
    logic [11:0] prev_v;

    function automatic logic [15:0] m_digits();
        return {nib_m[3], nib_m[2], nib_m[1], nib_m[0]};
    endfunction
    function automatic logic [3:0] m_pack(input int which);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i] = (which == 0) ? dpo_m[i] : (which == 1) ? val_m[i] : err_m[i];
        end
        return r;
    endfunction

    initial begin
        run_len = 0;
        prev_v  = 12'h000;
        berr_m  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nib_m[i] = 4'h0; val_m[i] = 1'b0; err_m[i] = 1'b0; dpo_m[i] = 1'b0;
        end
        forever begin
            @(posedge clk);
            edge_n++;
            if (rst_drv) begin
                run_len = 0;
                berr_m  = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    nib_m[i] = 4'h0; val_m[i] = 1'b0; err_m[i] = 1'b0; dpo_m[i] = 1'b0;
                end
            end else begin
                automatic logic [11:0] v = {an_drv, seg_drv, dp_drv};
                automatic int lows = 0;
                automatic int idx = 0;
                automatic int found = -1;
                if (run_len != 0 && v == prev_v) begin
                    if (run_len < 1000) run_len++;
                end else begin
                    run_len = 1;
                end
                prev_v = v;
                for (int i = 0; i < 4; i++) begin
                    if (!an_drv[i]) begin
                        lows++;
                        idx = i;
                    end
                end
                if (lows >= 2) berr_m = 1'b1;
                if (lows == 1 && run_len == SETTLE + 1) begin
                    automatic exp_t e;
                    for (int k = 0; k < 16; k++) begin
                        if (glyph_tab[k] == seg_drv) found = k;
                    end
                    if (found >= 0) begin
                        nib_m[idx] = 4'(found);
                        val_m[idx] = 1'b1;
                        err_m[idx] = 1'b0;
                    end else if (seg_drv == 7'h7F) begin
                        val_m[idx] = 1'b0;
                        err_m[idx] = 1'b0;
                    end else begin
                        val_m[idx] = 1'b0;
                        err_m[idx] = 1'b1;
                    end
                    dpo_m[idx] = ~dp_drv;
                    e.tag = edge_n;
                    e.vec = {2'(idx), m_digits(), m_pack(0), m_pack(1), m_pack(2), berr_m};
                    exp_q.push_back(e);
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0 && exp_q[0].tag < edge_n) begin
                n_total++;
                n_bad++;
                $display("FAIL missed_update: no update seen at edge %0d, required capture vec %0h",
                         exp_q[0].tag, exp_q[0].vec);
                void'(exp_q.pop_front());
            end
            if (ss_if.update) begin
                automatic logic [30:0] act = {ss_if.update_idx, ss_if.digits, ss_if.dp_out,
                                              ss_if.digit_valid, ss_if.decode_err, ss_if.bus_err};
                upd_cnt++;
                n_total++;
                if (exp_q.size() > 0 && exp_q[0].tag == edge_n) begin
                    automatic exp_t e = exp_q.pop_front();
                    if (act !== e.vec) begin
                        n_bad++;
                        $display("FAIL capture@%0d: got %0h required %0h", edge_n, act, e.vec);
                    end
                end else begin
                    n_bad++;
                    $display("FAIL unexpected_update@%0d: got update idx=%0d, required no update",
                             edge_n, ss_if.update_idx);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic hold(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
        @(negedge clk);
        an_drv  = a;
        seg_drv = s;
        dp_drv  = d;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_digits"}, 32'(ss_if.digits), 32'h0);
        chk({tag, "_dp_out"}, 32'(ss_if.dp_out), 32'h0);
        chk({tag, "_valid"}, 32'(ss_if.digit_valid), 32'h0);
        chk({tag, "_decerr"}, 32'(ss_if.decode_err), 32'h0);
        chk({tag, "_buserr"}, 32'(ss_if.bus_err), 32'h0);
        chk({tag, "_update"}, 32'(ss_if.update), 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int upd_before;
        rst_drv = 1'b1;
        an_drv  = 4'hF;
        seg_drv = 7'h7F;
        dp_drv  = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        chk("reset_fsm", 32'(ss_if.fsm_state), 32'h0);
        rst_drv = 1'b0;
        hold(4'hF, 7'h7F, 1'b1, 2);

        // Single digit '2' on digit 0.
        hold(4'b1110, 7'h24, 1'b1, 8);
        chk("t1_nibble", 32'(ss_if.digits[3:0]), 32'h2);
        chk("t1_valid", 32'(ss_if.digit_valid), 32'h1);
        chk("t1_dp0", 32'(ss_if.dp_out[0]), 32'h0);

        // Scan "1A3F", decimal point on digit 2.
        upd_before = upd_cnt;
        hold(4'b0111, 7'h79, 1'b1, 20); hold(4'hF, 7'h7F, 1'b1, 2);
        hold(4'b1011, 7'h08, 1'b0, 20); hold(4'hF, 7'h7F, 1'b1, 2);
        hold(4'b1101, 7'h30, 1'b1, 20); hold(4'hF, 7'h7F, 1'b1, 2);
        hold(4'b1110, 7'h0E, 1'b1, 20); hold(4'hF, 7'h7F, 1'b1, 2);
        chk("scan_digits", 32'(ss_if.digits), 32'h1A3F);
        chk("scan_dp", 32'(ss_if.dp_out), 32'h4);
        chk("scan_valid", 32'(ss_if.digit_valid), 32'hF);
        chk("scan_updates", 32'(upd_cnt - upd_before), 32'd4);

        // One-cycle glitch in the middle of a dwell on digit 1.
        upd_before = upd_cnt;
        hold(4'b1101, 7'h12, 1'b1, 2);
        hold(4'b1101, 7'h13, 1'b1, 1);
        hold(4'b1101, 7'h12, 1'b1, 10);
        hold(4'hF, 7'h7F, 1'b1, 2);
        chk("glitch_updates", 32'(upd_cnt - upd_before), 32'd1);
        chk("glitch_digit1", 32'(ss_if.digits[7:4]), 32'h5);

        // Illegal pattern on digit 3, then a legal '5'.
        hold(4'b0111, 7'h7E, 1'b1, 10);
        chk("bad_decerr3", 32'(ss_if.decode_err[3]), 32'h1);
        chk("bad_valid3", 32'(ss_if.digit_valid[3]), 32'h0);
        chk("bad_digit3", 32'(ss_if.digits[15:12]), 32'h1);
        hold(4'hF, 7'h7F, 1'b1, 2);
        hold(4'b0111, 7'h12, 1'b1, 10);
        chk("fix_decerr3", 32'(ss_if.decode_err[3]), 32'h0);
        chk("fix_digit3", 32'(ss_if.digits[15:12]), 32'h5);

        // Randomized dwells, including blanks, junk patterns and short dwells.
        for (int k = 0; k < 60; k++) begin
            automatic int sel_an  = $urandom_range(0, 4);
            automatic int sel_seg = $urandom_range(0, 17);
            automatic logic [3:0] a = (sel_an == 4) ? 4'hF : ~(4'b0001 << sel_an);
            automatic logic [6:0] s = (sel_seg < 16) ? glyph_tab[sel_seg] :
                                      (sel_seg == 16) ? 7'h7F : 7'($urandom_range(0, 127));
            hold(a, s, 1'($urandom_range(0, 1)), $urandom_range(1, 12));
        end
        hold(4'hF, 7'h7F, 1'b1, 2);

        // Anode conflict, then legal scans: bus_err stays set.
        hold(4'b1110, 7'h40, 1'b1, 3);
        upd_before = upd_cnt;
        hold(4'b1100, 7'h40, 1'b1, 1);
        chk("conflict_updates", 32'(upd_cnt - upd_before), 32'd0);
        hold(4'b1011, 7'h06, 1'b1, 10);
        hold(4'b1110, 7'h21, 1'b0, 10);
        hold(4'hF, 7'h7F, 1'b1, 2);
        chk("conflict_buserr", 32'(ss_if.bus_err), 32'h1);

        // Reset clears everything.
        @(negedge clk);
        rst_drv = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero_outputs("reset2");
        rst_drv = 1'b0;

        // Reset during a dwell, released with the inputs held.
        hold(4'b1110, 7'h19, 1'b1, 2);
        rst_drv = 1'b1;
        repeat (2) @(negedge clk);
        rst_drv = 1'b0;
        upd_before = upd_cnt;
        repeat (4) @(negedge clk);
        chk("rst_dwell_early", 32'(upd_cnt - upd_before), 32'd0);
        repeat (6) @(negedge clk);
        chk("rst_dwell_updates", 32'(upd_cnt - upd_before), 32'd1);
        chk("rst_dwell_digits", 32'(ss_if.digits), 32'h0004);
        chk("rst_dwell_valid", 32'(ss_if.digit_valid), 32'h1);

        // Final agreement with the model.
        hold(4'hF, 7'h7F, 1'b1, 4);
        chk("final_queue", 32'(exp_q.size()), 32'd0);
        chk("final_digits", 32'(ss_if.digits), 32'(m_digits()));
        chk("final_dp", 32'(ss_if.dp_out), 32'(m_pack(0)));
        chk("final_valid", 32'(ss_if.digit_valid), 32'(m_pack(1)));
        chk("final_decerr", 32'(ss_if.decode_err), 32'(m_pack(2)));
        chk("final_buserr", 32'(ss_if.bus_err), 32'(berr_m));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
